nan_eye_capture_ctrl: RTL and testbench
=======================================

// Module: nan_eye_capture_ctrl
// PURPOSE
//  Frame-capture sequencer for the NanEye RX path. Drives the frame-sync enable of the
//  deserializer, counts received pixels into rows/columns, tags SOF/EOL and buffers
//  pixels in a small FIFO with a valid/ready handshake to downstream. Detects frame
//  completion, stalled links (timeout) and FIFO overflow; supports single-shot and
//  continuous capture.
// PARAMETERS
//  C_ROWS        250   rows per frame
//  C_COLS        250   pixels per row
//  C_ARM_CYCLES  16    cycles SYNC_EN held low before each frame (clears deserializer sreg)
//  C_TIMEOUT     65535 max idle cycles between pixels in CAPTURE (16-bit counter)
//  C_FIFO_AW     2     FIFO address width; depth = 2**C_FIFO_AW
// PORTS
//  SCLOCK        in   1   serial/pixel clock, all logic rising-edge
//  RESET         in   1   asynchronous, active-high reset
//  CAPTURE_REQ   in   1   start request, level sampled in IDLE only
//  CONT_MODE     in   1   1 = re-arm automatically after DONE/ERROR
//  ABORT         in   1   synchronous abort, highest priority
//  RX_PIX        in   10  pixel word from deserializer
//  RX_PIX_VLD    in   1   1-cycle strobe, RX_PIX valid
//  SYNC_EN       out  1   frame-sync enable to deserializer (0 = hold in reset)
//  PIX_DATA      out  10  FIFO head pixel
//  PIX_SOF       out  1   head pixel is row 0 col 0
//  PIX_EOL       out  1   head pixel is col C_COLS-1
//  PIX_VLD       out  1   FIFO non-empty
//  PIX_RDY       in   1   downstream accept; pop when PIX_VLD & PIX_RDY
//  FRAME_DONE    out  1   1-cycle pulse, last pixel of frame received
//  ERR_TIMEOUT   out  1   1-cycle pulse on timeout
//  ERR_OVF       out  1   sticky overflow flag, cleared on ARM entry
//  BUSY          out  1   state != IDLE
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; counters 0; FIFO empty.
//  States: IDLE -> ARM -> CAPTURE -> DONE | ERROR -> IDLE/ARM.
//   IDLE: SYNC_EN=0; CAPTURE_REQ=1 -> ARM next cycle. CAPTURE_REQ ignored elsewhere.
//   ARM: SYNC_EN=0, clear row/col/timeout, clear ERR_OVF; after exactly C_ARM_CYCLES
//     cycles in ARM -> CAPTURE. SYNC_EN=1 from first CAPTURE cycle (registered).
//   CAPTURE: SYNC_EN=1. On RX_PIX_VLD: push {SOF,EOL,RX_PIX}; col++; at col=C_COLS-1
//     col<=0,row++. Pixel (C_ROWS-1,C_COLS-1) -> DONE. Timeout counter resets on
//     RX_PIX_VLD, else increments; reaching C_TIMEOUT -> ERROR.
//   DONE: FRAME_DONE=1 (one cycle); SYNC_EN=0; CONT_MODE ? ARM : IDLE.
//   ERROR: ERR_TIMEOUT=1 (one cycle); SYNC_EN=0; FIFO retained; CONT_MODE ? ARM : IDLE.
//   ABORT=1 in any state: IDLE next cycle, SYNC_EN=0, FIFO flushed, no pulses.
//  RX_PIX_VLD outside CAPTURE is ignored (no push, no count).
//  FIFO: push accepted if not full, or full with pop in same cycle. Push when full
//   without pop: pixel dropped, ERR_OVF set, row/col still advance. Pop on empty: no-op.
//   Write-to-read latency 1 cycle (PIX_VLD rises the cycle after the push).
//  Widths: row/col counters $clog2(max(C_ROWS,C_COLS)) bits, wrap handled by compare,
//   never by overflow. Timeout counter saturates at C_TIMEOUT.
//  Reset mid-frame: immediate return to reset state; no partial FRAME_DONE.
// STRUCTURE
//  nan_eye_pkg: state encodings (IDLE/ARM/CAPTURE/DONE/ERROR), FIFO entry layout
//   {SOF,EOL,DATA[9:0]} = 12 bits, default C_ROWS/C_COLS.
//  Sub-module nan_eye_pix_fifo: synchronous FIFO, 12-bit wide, 2**C_FIFO_AW deep,
//   with push/pop/flush/full/empty; the controller FSM and counters live in this block.
// TESTING
//  1 Single frame, C_ROWS=C_COLS=4, PIX_RDY=1, 16 strobes -> 16 pops, SOF on 1st,
//    EOL on 4/8/12/16, FRAME_DONE once, back to IDLE, SYNC_EN=0.
//  2 CONT_MODE=1, 2 frames -> ARM holds SYNC_EN=0 for C_ARM_CYCLES between frames,
//    two FRAME_DONE pulses, SOF on pixel 0 of each frame.
//  3 C_TIMEOUT=20, stop strobes after 5 pixels -> ERR_TIMEOUT pulse 20 cycles after
//    last strobe, SYNC_EN=0, 5 pixels still poppable.
//  4 PIX_RDY=0, 6 strobes with depth 4 -> 4 entries held, ERR_OVF=1 after 5th strobe,
//    col count = 6; ERR_OVF cleared on next ARM entry.
//  5 Full FIFO with push and pop same cycle -> push accepted, no ERR_OVF.
//  6 ABORT mid-row and RESET mid-frame -> IDLE next cycle/immediately, FIFO empty,
//    no FRAME_DONE, new CAPTURE_REQ starts a clean frame with SOF.

Source files
------------

// File: rtl/nan_eye_pkg.sv
// Shared types for the NanEye capture path: FSM state encoding, FIFO entry layout
// and default frame geometry.
package nan_eye_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARM     = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_DONE    = 3'd3,
        ST_ERROR   = 3'd4
    } state_t;

    localparam int PIX_W          = 10;
    localparam int ENTRY_W        = PIX_W + 2;
    localparam int TMO_W          = 16;
    localparam int DEF_ROWS       = 250;
    localparam int DEF_COLS       = 250;
    localparam int DEF_ARM_CYCLES = 16;
    localparam int DEF_TIMEOUT    = 65535;

    typedef struct packed {
        logic             sof;
        logic             eol;
        logic [PIX_W-1:0] data;
    } pix_entry_t;

    // Row/column counters share one width, sized for the larger dimension.
    function automatic int rc_width(input int rows, input int cols);
        int m;
        m = (rows > cols) ? rows : cols;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/nan_eye_pix_fifo.sv
// Small show-ahead pixel FIFO; the head entry is visible the cycle after it is written.
// A push into a full FIFO is accepted only when the head is popped in the same cycle.
module nan_eye_pix_fifo
    import nan_eye_pkg::*;
#(
    parameter int AW = 2
)(
    input  logic       SCLOCK,
    input  logic       RESET,
    input  logic       flush,
    input  logic       push,
    input  pix_entry_t wr_entry,
    input  logic       pop,
    output pix_entry_t rd_entry,
    output logic       full,
    output logic       empty,
    output logic       drop
);

    localparam int DEPTH = 1 << AW;
    localparam logic [AW-1:0] PTR_ONE = 1;
    localparam logic [AW:0]   CNT_ONE = 1;
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [AW-1:0]      wr_ptr_reg;
    logic [AW-1:0]      rd_ptr_reg;
    logic [AW:0]        count_reg;
    logic               do_push;
    logic               do_pop;

    assign full    = (count_reg == CNT_FULL);
    assign empty   = (count_reg == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign drop    = push && full && !do_pop;

    // Head fields read as zero while empty so the outputs stay quiet between frames.
    assign rd_entry = empty ? '0 : pix_entry_t'(mem[rd_ptr_reg]);

    always_ff @(posedge SCLOCK) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= wr_entry;
        end
    end

    always_ff @(posedge SCLOCK or posedge RESET) begin
        if (RESET) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CNT_ONE;
                2'b01:   count_reg <= count_reg - CNT_ONE;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/nan_eye_capture_ctrl.sv
// NanEye frame-capture sequencer: arms the deserializer, counts pixels into rows and
// columns, tags SOF/EOL into a small FIFO and flags frame end, link stalls and overflow.
module nan_eye_capture_ctrl
    import nan_eye_pkg::*;
#(
    parameter int C_ROWS       = DEF_ROWS,
    parameter int C_COLS       = DEF_COLS,
    parameter int C_ARM_CYCLES = DEF_ARM_CYCLES,
    parameter int C_TIMEOUT    = DEF_TIMEOUT,
    parameter int C_FIFO_AW    = 2
)(
    input  logic             SCLOCK,
    input  logic             RESET,
    input  logic             CAPTURE_REQ,
    input  logic             CONT_MODE,
    input  logic             ABORT,
    input  logic [PIX_W-1:0] RX_PIX,
    input  logic             RX_PIX_VLD,
    output logic             SYNC_EN,
    output logic [PIX_W-1:0] PIX_DATA,
    output logic             PIX_SOF,
    output logic             PIX_EOL,
    output logic             PIX_VLD,
    input  logic             PIX_RDY,
    output logic             FRAME_DONE,
    output logic             ERR_TIMEOUT,
    output logic             ERR_OVF,
    output logic             BUSY
);

    localparam int RC_W  = rc_width(C_ROWS, C_COLS);
    localparam int ARM_W = (C_ARM_CYCLES > 1) ? $clog2(C_ARM_CYCLES) : 1;

    localparam logic [RC_W-1:0]  LAST_ROW = RC_W'(C_ROWS - 1);
    localparam logic [RC_W-1:0]  LAST_COL = RC_W'(C_COLS - 1);
    localparam logic [RC_W-1:0]  RC_ONE   = 1;
    localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(C_ARM_CYCLES - 1);
    localparam logic [ARM_W-1:0] ARM_ONE  = 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(C_TIMEOUT - 1);
    localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(C_TIMEOUT);
    localparam logic [TMO_W-1:0] TMO_ONE  = 1;

    state_t           state_reg;
    logic [RC_W-1:0]  row_reg;
    logic [RC_W-1:0]  col_reg;
    logic [TMO_W-1:0] tmo_reg;
    logic [ARM_W-1:0] arm_reg;
    logic             sync_en_reg;
    logic             frame_done_reg;
    logic             err_timeout_reg;
    logic             err_ovf_reg;
    logic             busy_reg;

    logic       arm_entry;
    logic       pix_take;
    pix_entry_t push_entry;
    pix_entry_t head_entry;
    logic       fifo_full;
    logic       fifo_empty;
    logic       fifo_drop;

    // Pixels are only counted and stored while capturing; ABORT beats everything.
    assign pix_take = (state_reg == ST_CAPTURE) && RX_PIX_VLD && !ABORT;

    assign push_entry.sof  = (row_reg == '0) && (col_reg == '0);
    assign push_entry.eol  = (col_reg == LAST_COL);
    assign push_entry.data = RX_PIX;

    always_comb begin
        arm_entry = 1'b0;
        if (!ABORT) begin
            case (state_reg)
                ST_IDLE:           arm_entry = CAPTURE_REQ;
                ST_DONE, ST_ERROR: arm_entry = CONT_MODE;
                default:           arm_entry = 1'b0;
            endcase
        end
    end

    nan_eye_pix_fifo #(
        .AW (C_FIFO_AW)
    ) u_fifo (
        .SCLOCK   (SCLOCK),
        .RESET    (RESET),
        .flush    (ABORT),
        .push     (pix_take),
        .wr_entry (push_entry),
        .pop      (PIX_RDY),
        .rd_entry (head_entry),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .drop     (fifo_drop)
    );

    always_ff @(posedge SCLOCK or posedge RESET) begin
        if (RESET) begin
            state_reg       <= ST_IDLE;
            row_reg         <= '0;
            col_reg         <= '0;
            tmo_reg         <= '0;
            arm_reg         <= '0;
            sync_en_reg     <= 1'b0;
            frame_done_reg  <= 1'b0;
            err_timeout_reg <= 1'b0;
            err_ovf_reg     <= 1'b0;
            busy_reg        <= 1'b0;
        end else begin
            frame_done_reg  <= 1'b0;
            err_timeout_reg <= 1'b0;
            if (fifo_drop) begin
                err_ovf_reg <= 1'b1;
            end

            if (ABORT) begin
                state_reg   <= ST_IDLE;
                sync_en_reg <= 1'b0;
                busy_reg    <= 1'b0;
            end else if (arm_entry) begin
                // Every frame starts from a clean slate, including the overflow flag.
                state_reg   <= ST_ARM;
                arm_reg     <= '0;
                row_reg     <= '0;
                col_reg     <= '0;
                tmo_reg     <= '0;
                err_ovf_reg <= 1'b0;
                sync_en_reg <= 1'b0;
                busy_reg    <= 1'b1;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        sync_en_reg <= 1'b0;
                    end
                    ST_ARM: begin
                        if (arm_reg == ARM_LAST) begin
                            state_reg   <= ST_CAPTURE;
                            sync_en_reg <= 1'b1;
                        end else begin
                            arm_reg <= arm_reg + ARM_ONE;
                        end
                    end
                    ST_CAPTURE: begin
                        if (pix_take) begin
                            tmo_reg <= '0;
                            if (col_reg == LAST_COL) begin
                                col_reg <= '0;
                                if (row_reg == LAST_ROW) begin
                                    row_reg        <= '0;
                                    state_reg      <= ST_DONE;
                                    frame_done_reg <= 1'b1;
                                    sync_en_reg    <= 1'b0;
                                end else begin
                                    row_reg <= row_reg + RC_ONE;
                                end
                            end else begin
                                col_reg <= col_reg + RC_ONE;
                            end
                        end else if (tmo_reg == TMO_LAST) begin
                            tmo_reg         <= TMO_MAX;
                            state_reg       <= ST_ERROR;
                            err_timeout_reg <= 1'b1;
                            sync_en_reg     <= 1'b0;
                        end else if (tmo_reg != TMO_MAX) begin
                            tmo_reg <= tmo_reg + TMO_ONE;
                        end
                    end
                    ST_DONE, ST_ERROR: begin
                        state_reg   <= ST_IDLE;
                        sync_en_reg <= 1'b0;
                        busy_reg    <= 1'b0;
                    end
                    default: begin
                        state_reg   <= ST_IDLE;
                        sync_en_reg <= 1'b0;
                        busy_reg    <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign SYNC_EN     = sync_en_reg;
    assign FRAME_DONE  = frame_done_reg;
    assign ERR_TIMEOUT = err_timeout_reg;
    assign ERR_OVF     = err_ovf_reg;
    assign BUSY        = busy_reg;
    assign PIX_VLD     = !fifo_empty;
    assign PIX_DATA    = head_entry.data;
    assign PIX_SOF     = head_entry.sof;
    assign PIX_EOL     = head_entry.eol;

endmodule

// File: tb/tb_nan_eye_capture_ctrl.sv
// Bench for nan_eye_capture_ctrl on a 4x4 frame: directed scenarios plus a randomized
// stream, all compared cycle by cycle against a pixel-index/queue model of the capture path.
module tb_nan_eye_capture_ctrl;

    localparam int ROWS  = 4;
    localparam int COLS  = 4;
    localparam int ARM   = 16;
    localparam int TMO   = 20;
    localparam int AW    = 2;
    localparam int DEPTH = 4;
    localparam int NPIX  = ROWS * COLS;

    localparam int M_IDLE = 0;
    localparam int M_ARM  = 1;
    localparam int M_CAP  = 2;
    localparam int M_DONE = 3;
    localparam int M_ERR  = 4;

    logic       SCLOCK = 1'b0;
    logic       RESET = 1'b1;
    logic       CAPTURE_REQ = 1'b0;
    logic       CONT_MODE = 1'b0;
    logic       ABORT = 1'b0;
    logic [9:0] RX_PIX = '0;
    logic       RX_PIX_VLD = 1'b0;
    logic       PIX_RDY = 1'b0;
    logic       SYNC_EN;
    logic [9:0] PIX_DATA;
    logic       PIX_SOF;
    logic       PIX_EOL;
    logic       PIX_VLD;
    logic       FRAME_DONE;
    logic       ERR_TIMEOUT;
    logic       ERR_OVF;
    logic       BUSY;

    int checks = 0;
    int failures = 0;

    always #5 SCLOCK = ~SCLOCK;

    nan_eye_capture_ctrl #(
        .C_ROWS       (ROWS),
        .C_COLS       (COLS),
        .C_ARM_CYCLES (ARM),
        .C_TIMEOUT    (TMO),
        .C_FIFO_AW    (AW)
    ) dut (
        .SCLOCK      (SCLOCK),
        .RESET       (RESET),
        .CAPTURE_REQ (CAPTURE_REQ),
        .CONT_MODE   (CONT_MODE),
        .ABORT       (ABORT),
        .RX_PIX      (RX_PIX),
        .RX_PIX_VLD  (RX_PIX_VLD),
        .SYNC_EN     (SYNC_EN),
        .PIX_DATA    (PIX_DATA),
        .PIX_SOF     (PIX_SOF),
        .PIX_EOL     (PIX_EOL),
        .PIX_VLD     (PIX_VLD),
        .PIX_RDY     (PIX_RDY),
        .FRAME_DONE  (FRAME_DONE),
        .ERR_TIMEOUT (ERR_TIMEOUT),
        .ERR_OVF     (ERR_OVF),
        .BUSY        (BUSY)
    );

    // Model: frame position is a flat pixel index, the FIFO is a bounded queue.
    int         m_mode;
    int         m_arm_left;
    int         m_idx;
    int         m_idle;
    bit         e_sync;
    bit         e_done;
    bit         e_tmo;
    bit         e_ovf;
    logic [11:0] m_q[$];

    task automatic model_reset();
        m_mode = M_IDLE;
        m_arm_left = 0;
        m_idx = 0;
        m_idle = 0;
        e_sync = 0;
        e_done = 0;
        e_tmo = 0;
        e_ovf = 0;
        m_q.delete();
    endtask

    task automatic model_enter_arm();
        m_mode = M_ARM;
        m_arm_left = ARM;
        m_idx = 0;
        m_idle = 0;
        e_ovf = 0;
        e_sync = 0;
    endtask

    task automatic tick();
        bit pop;
        bit take;
        logic [11:0] ent;
        pop  = (m_q.size() > 0) && PIX_RDY;
        take = (m_mode == M_CAP) && RX_PIX_VLD && !ABORT;
        ent  = {(m_idx == 0), ((m_idx % COLS) == COLS - 1), RX_PIX};
        @(posedge SCLOCK);
        #1;
        e_done = 0;
        e_tmo = 0;
        if (ABORT) begin
            m_q.delete();
            m_mode = M_IDLE;
            e_sync = 0;
        end else begin
            if (pop) void'(m_q.pop_front());
            if (take) begin
                if (m_q.size() < DEPTH) m_q.push_back(ent);
                else e_ovf = 1;
            end
            case (m_mode)
                M_IDLE: if (CAPTURE_REQ) model_enter_arm();
                M_ARM: begin
                    m_arm_left--;
                    if (m_arm_left == 0) begin
                        m_mode = M_CAP;
                        e_sync = 1;
                    end
                end
                M_CAP: begin
                    if (take) begin
                        m_idx++;
                        m_idle = 0;
                        if (m_idx == NPIX) begin
                            m_mode = M_DONE;
                            e_done = 1;
                            e_sync = 0;
                        end
                    end else begin
                        m_idle++;
                        if (m_idle == TMO) begin
                            m_mode = M_ERR;
                            e_tmo = 1;
                            e_sync = 0;
                        end
                    end
                end
                default: begin
                    if (CONT_MODE) model_enter_arm();
                    else m_mode = M_IDLE;
                end
            endcase
        end
    endtask

    function automatic logic [17:0] obs_vec();
        return {SYNC_EN, FRAME_DONE, ERR_TIMEOUT, ERR_OVF, BUSY, PIX_VLD, PIX_SOF, PIX_EOL, PIX_DATA};
    endfunction

    function automatic logic [17:0] exp_vec();
        logic [11:0] head;
        head = (m_q.size() > 0) ? m_q[0] : 12'h000;
        return {e_sync, e_done, e_tmo, e_ovf, (m_mode != M_IDLE), (m_q.size() > 0), head};
    endfunction

    task automatic start_frame();
        RX_PIX_VLD = 0;
        CAPTURE_REQ = 1;
        tick();
        CAPTURE_REQ = 0;
        for (int i = 0; i < ARM + 4 && m_mode != M_CAP; i++) tick();
    endtask

    task automatic test_reset();
        repeat (3) @(posedge SCLOCK);
        #1;
        model_reset();
        checks++;
        if (obs_vec() !== 18'h0) begin
            failures++;
            $display("FAIL reset_outputs: got %h want %h", obs_vec(), 18'h0);
        end
        RESET = 0;
        tick();
        checks++;
        if (obs_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL reset_idle: got %h want %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_single_frame();
        int pops;
        int dones;
        pops = 0;
        dones = 0;
        CONT_MODE = 0;
        PIX_RDY = 1;
        CAPTURE_REQ = 1;
        tick();
        CAPTURE_REQ = 0;
        for (int c = 0; c < 400 && !(m_mode == M_IDLE && m_q.size() == 0); c++) begin
            RX_PIX_VLD = (m_idle >= 8) || ($urandom_range(0, 2) == 0);
            RX_PIX = 10'($urandom);
            if (PIX_VLD && PIX_RDY) begin
                checks++;
                if ({PIX_SOF, PIX_EOL} !== {(pops == 0), ((pops % COLS) == COLS - 1)}) begin
                    failures++;
                    $display("FAIL single_tags pop %0d: got %b want %b", pops, {PIX_SOF, PIX_EOL},
                             {(pops == 0), ((pops % COLS) == COLS - 1)});
                end
                pops++;
            end
            tick();
            if (FRAME_DONE) dones++;
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL single_cycle %0d: got %h want %h", c, obs_vec(), exp_vec());
            end
        end
        RX_PIX_VLD = 0;
        checks++;
        if (pops !== NPIX) begin
            failures++;
            $display("FAIL single_pops: got %0d want %0d", pops, NPIX);
        end
        checks++;
        if (dones !== 1) begin
            failures++;
            $display("FAIL single_done_count: got %0d want 1", dones);
        end
        checks++;
        if ({BUSY, SYNC_EN} !== 2'b00) begin
            failures++;
            $display("FAIL single_end_idle: got %b want 00", {BUSY, SYNC_EN});
        end
    endtask

    task automatic test_continuous();
        int pops;
        int sofs;
        int dones;
        int gap;
        pops = 0;
        sofs = 0;
        dones = 0;
        gap = 0;
        CONT_MODE = 1;
        PIX_RDY = 1;
        CAPTURE_REQ = 1;
        tick();
        CAPTURE_REQ = 0;
        for (int c = 0; c < 800 && !(dones == 2 && m_mode == M_IDLE && m_q.size() == 0); c++) begin
            RX_PIX_VLD = (m_idle >= 8) || ($urandom_range(0, 1) == 0);
            RX_PIX = 10'($urandom);
            if (PIX_VLD && PIX_RDY) begin
                pops++;
                if (PIX_SOF) sofs++;
            end
            tick();
            if (FRAME_DONE) dones++;
            if (dones == 1 && !SYNC_EN) gap++;
            if (dones == 1 && SYNC_EN) CONT_MODE = 0;
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL cont_cycle %0d: got %h want %h", c, obs_vec(), exp_vec());
            end
        end
        RX_PIX_VLD = 0;
        checks++;
        if (dones !== 2) begin
            failures++;
            $display("FAIL cont_done_count: got %0d want 2", dones);
        end
        // Between frames SYNC_EN is low for the DONE cycle plus the whole ARM window.
        checks++;
        if (gap !== ARM + 1) begin
            failures++;
            $display("FAIL cont_sync_gap: got %0d want %0d", gap, ARM + 1);
        end
        checks++;
        if ({sofs, pops} !== {32'd2, 32'(2 * NPIX)}) begin
            failures++;
            $display("FAIL cont_sof_pops: got sof=%0d pops=%0d want sof=2 pops=%0d", sofs, pops, 2 * NPIX);
        end
    endtask

    task automatic test_timeout();
        logic [9:0] val[5];
        logic [9:0] got[$];
        int n;
        CONT_MODE = 0;
        PIX_RDY = 0;
        start_frame();
        for (int k = 0; k < 5; k++) begin
            if (k > 0) begin
                RX_PIX_VLD = 0;
                PIX_RDY = 0;
                tick();
            end
            val[k] = 10'($urandom);
            RX_PIX = val[k];
            RX_PIX_VLD = 1;
            PIX_RDY = (k == 4);
            if (k == 4 && PIX_VLD) got.push_back(PIX_DATA);
            tick();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL tmo_strobe %0d: got %h want %h", k, obs_vec(), exp_vec());
            end
        end
        RX_PIX_VLD = 0;
        PIX_RDY = 0;
        checks++;
        if (ERR_OVF !== 1'b0) begin
            failures++;
            $display("FAIL full_push_pop_ovf: got %b want 0", ERR_OVF);
        end
        n = 0;
        while (!ERR_TIMEOUT && n < 40) begin
            tick();
            n++;
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL tmo_idle %0d: got %h want %h", n, obs_vec(), exp_vec());
            end
        end
        checks++;
        if (n !== TMO) begin
            failures++;
            $display("FAIL tmo_latency: got %0d want %0d", n, TMO);
        end
        checks++;
        if ({ERR_TIMEOUT, SYNC_EN} !== 2'b10) begin
            failures++;
            $display("FAIL tmo_flags: got %b want 10", {ERR_TIMEOUT, SYNC_EN});
        end
        tick();
        PIX_RDY = 1;
        for (int i = 0; i < 10 && PIX_VLD; i++) begin
            got.push_back(PIX_DATA);
            tick();
        end
        checks++;
        if (got.size() !== 5) begin
            failures++;
            $display("FAIL tmo_retained: got %0d want 5", got.size());
        end
        for (int i = 0; i < 5 && i < got.size(); i++) begin
            checks++;
            if (got[i] !== val[i]) begin
                failures++;
                $display("FAIL tmo_data %0d: got %h want %h", i, got[i], val[i]);
            end
        end
    endtask

    task automatic test_overflow();
        logic [9:0] val[16];
        logic [9:0] got[$];
        CONT_MODE = 0;
        PIX_RDY = 0;
        start_frame();
        for (int k = 0; k < 16; k++) begin
            val[k] = 10'($urandom);
            RX_PIX = val[k];
            RX_PIX_VLD = 1;
            tick();
            if (k == 3 || k == 4) begin
                checks++;
                if (ERR_OVF !== (k == 4)) begin
                    failures++;
                    $display("FAIL ovf_flag strobe %0d: got %b want %b", k + 1, ERR_OVF, (k == 4));
                end
            end
            checks++;
            if (FRAME_DONE !== (k == 15)) begin
                failures++;
                $display("FAIL ovf_done strobe %0d: got %b want %b", k + 1, FRAME_DONE, (k == 15));
            end
            RX_PIX_VLD = 0;
            tick();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL ovf_cycle %0d: got %h want %h", k, obs_vec(), exp_vec());
            end
        end
        PIX_RDY = 1;
        for (int i = 0; i < 10 && PIX_VLD; i++) begin
            got.push_back(PIX_DATA);
            tick();
        end
        checks++;
        if (got.size() !== DEPTH) begin
            failures++;
            $display("FAIL ovf_held: got %0d want %0d", got.size(), DEPTH);
        end
        for (int i = 0; i < DEPTH && i < got.size(); i++) begin
            checks++;
            if (got[i] !== val[i]) begin
                failures++;
                $display("FAIL ovf_data %0d: got %h want %h", i, got[i], val[i]);
            end
        end
        CAPTURE_REQ = 1;
        tick();
        CAPTURE_REQ = 0;
        checks++;
        if ({ERR_OVF, BUSY} !== 2'b01) begin
            failures++;
            $display("FAIL ovf_clear_on_arm: got %b want 01", {ERR_OVF, BUSY});
        end
        ABORT = 1;
        tick();
        ABORT = 0;
    endtask

    task automatic test_back_to_back();
        logic [9:0] val[5];
        PIX_RDY = 0;
        start_frame();
        for (int k = 0; k < 5; k++) begin
            val[k] = 10'($urandom);
            RX_PIX = val[k];
            RX_PIX_VLD = 1;
            PIX_RDY = (k == 4);
            tick();
        end
        RX_PIX_VLD = 0;
        PIX_RDY = 0;
        checks++;
        if ({ERR_OVF, PIX_VLD, PIX_DATA} !== {1'b0, 1'b1, val[1]}) begin
            failures++;
            $display("FAIL b2b_full_swap: got ovf=%b vld=%b data=%h want ovf=0 vld=1 data=%h",
                     ERR_OVF, PIX_VLD, PIX_DATA, val[1]);
        end
        checks++;
        if (obs_vec() !== exp_vec()) begin
            failures++;
            $display("FAIL b2b_model: got %h want %h", obs_vec(), exp_vec());
        end
        ABORT = 1;
        tick();
        ABORT = 0;
    endtask

    task automatic test_abort_reset();
        PIX_RDY = 0;
        start_frame();
        for (int k = 0; k < 6; k++) begin
            RX_PIX = 10'($urandom);
            RX_PIX_VLD = 1;
            tick();
        end
        RX_PIX_VLD = 0;
        ABORT = 1;
        tick();
        ABORT = 0;
        checks++;
        if ({BUSY, SYNC_EN, PIX_VLD, FRAME_DONE} !== 4'b0000) begin
            failures++;
            $display("FAIL abort_idle: got %b want 0000", {BUSY, SYNC_EN, PIX_VLD, FRAME_DONE});
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL abort_after %0d: got %h want %h", i, obs_vec(), exp_vec());
            end
        end
        start_frame();
        RX_PIX = 10'($urandom);
        RX_PIX_VLD = 1;
        tick();
        RX_PIX_VLD = 0;
        checks++;
        if ({PIX_VLD, PIX_SOF, ERR_OVF} !== 3'b110) begin
            failures++;
            $display("FAIL abort_restart_sof: got %b want 110", {PIX_VLD, PIX_SOF, ERR_OVF});
        end
        for (int k = 0; k < 3; k++) begin
            RX_PIX = 10'($urandom);
            RX_PIX_VLD = 1;
            tick();
        end
        RX_PIX_VLD = 0;
        RESET = 1;
        #2;
        model_reset();
        checks++;
        if (obs_vec() !== 18'h0) begin
            failures++;
            $display("FAIL reset_midframe: got %h want %h", obs_vec(), 18'h0);
        end
        @(posedge SCLOCK);
        #1;
        RESET = 0;
        start_frame();
        RX_PIX = 10'($urandom);
        RX_PIX_VLD = 1;
        tick();
        RX_PIX_VLD = 0;
        checks++;
        if ({PIX_VLD, PIX_SOF, SYNC_EN} !== 3'b111) begin
            failures++;
            $display("FAIL reset_restart_sof: got %b want 111", {PIX_VLD, PIX_SOF, SYNC_EN});
        end
        ABORT = 1;
        tick();
        ABORT = 0;
    endtask

    task automatic test_random_stream();
        for (int c = 0; c < 2000; c++) begin
            if (c % 250 == 0) CONT_MODE = 1'($urandom_range(0, 1));
            CAPTURE_REQ = ($urandom_range(0, 9) == 0);
            ABORT = ($urandom_range(0, 299) == 0);
            PIX_RDY = ($urandom_range(0, 99) < 60);
            RX_PIX_VLD = (c % 400 < 360) && ($urandom_range(0, 99) < 45);
            RX_PIX = 10'($urandom);
            tick();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL random_cycle %0d: got %h want %h", c, obs_vec(), exp_vec());
            end
        end
        CAPTURE_REQ = 0;
        RX_PIX_VLD = 0;
        CONT_MODE = 0;
        ABORT = 1;
        tick();
        ABORT = 0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_frame();
        test_continuous();
        test_timeout();
        test_overflow();
        test_back_to_back();
        test_abort_reset();
        test_random_stream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
